// File: rtl/flag_branch_if.sv
// EX-stage / branch-resolution bundle between the pipeline and flag_branch_unit.
// The master drives ALU results and branch requests; the slave returns flags and redirects.
interface flag_branch_if #(
    parameter int PC_W  = 16,
    parameter int OFF_W = 9
);
    logic             stall;
    logic             flush;
    logic             ex_valid;
    logic [2:0]       ex_ctrl;
    logic             ex_is_addz;
    logic             ex_ov;
    logic             ex_zr;
    logic             ex_ne;
    logic             br_valid;
    logic [2:0]       br_cond;
    logic [PC_W-1:0]  br_pc_inc;
    logic [OFF_W-1:0] br_offset;
    logic             flag_z;
    logic             flag_v;
    logic             flag_n;
    logic             addz_wr_en;
    logic             redirect;
    logic [PC_W-1:0]  redirect_pc;

    modport master (
        output stall, flush, ex_valid, ex_ctrl, ex_is_addz, ex_ov, ex_zr, ex_ne,
               br_valid, br_cond, br_pc_inc, br_offset,
        input  flag_z, flag_v, flag_n, addz_wr_en, redirect, redirect_pc
    );

    modport slave (
        input  stall, flush, ex_valid, ex_ctrl, ex_is_addz, ex_ov, ex_zr, ex_ne,
               br_valid, br_cond, br_pc_inc, br_offset,
        output flag_z, flag_v, flag_n, addz_wr_en, redirect, redirect_pc
    );
endinterface

// File: rtl/flag_branch_unit.sv
// Architectural Z/V/N flag register, conditional-branch resolution and addz gating
// for the 16-bit pipelined CPU; issues a registered one-cycle redirect to fetch.
module flag_branch_unit #(
    parameter int PC_W  = 16,
    parameter int OFF_W = 9
) (
    input  logic         clk,
    input  logic         rst,
    flag_branch_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SHADOW   = 2'd2
    } state_t;

    state_t            state_r, state_nxt_s;
    logic              flag_z_r, flag_v_r, flag_n_r;
    logic              zb_s, vb_s, nb_s;
    logic              redirect_r, redirect_nxt_s;
    logic [PC_W-1:0]   redirect_pc_r, redirect_pc_nxt_s;
    logic [PC_W-1:0]   target_s;
    logic              upd_s;
    logic              addz_wr_en_s;
    logic              taken_s;

    function automatic logic cond_taken(input logic [2:0] cond, input logic zb,
                                        input logic vb, input logic nb);
        logic t;
        case (cond)
            3'b000:  t = ~zb;
            3'b001:  t = zb;
            3'b010:  t = ~zb & ~nb;
            3'b011:  t = nb;
            3'b100:  t = zb | ~nb;
            3'b101:  t = nb | zb;
            3'b110:  t = vb;
            3'b111:  t = 1'b1;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    assign upd_s        = bus.ex_valid & ~bus.flush & ~bus.stall;
    assign addz_wr_en_s = bus.ex_valid & bus.ex_is_addz & flag_z_r & ~bus.flush;
    assign target_s     = bus.br_pc_inc + {{(PC_W-OFF_W){bus.br_offset[OFF_W-1]}}, bus.br_offset};
    // Zb/Vb/Nb are the next-state flags, so a same-cycle ALU result feeds the branch directly.
    assign taken_s      = cond_taken(bus.br_cond, zb_s, vb_s, nb_s);

    // Next-state flag values from the EX-stage ALU op.
    always_comb begin
        zb_s = flag_z_r;
        vb_s = flag_v_r;
        nb_s = flag_n_r;
        if (upd_s) begin
            case (bus.ex_ctrl)
                3'b000: begin
                    if (!bus.ex_is_addz || addz_wr_en_s) begin
                        zb_s = bus.ex_zr;
                        vb_s = bus.ex_ov;
                        nb_s = bus.ex_ne;
                    end else begin
                        zb_s = flag_z_r;
                    end
                end
                3'b010: begin
                    zb_s = bus.ex_zr;
                    vb_s = bus.ex_ov;
                    nb_s = bus.ex_ne;
                end
                3'b001:  zb_s = flag_z_r;
                default: zb_s = bus.ex_zr;
            endcase
        end else begin
            zb_s = flag_z_r;
        end
    end

    // Redirect FSM next state and registered-output next values.
    always_comb begin
        state_nxt_s       = state_r;
        redirect_nxt_s    = redirect_r;
        redirect_pc_nxt_s = redirect_pc_r;
        if (bus.stall) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.br_valid && !bus.flush && taken_s) begin
                        redirect_nxt_s    = 1'b1;
                        redirect_pc_nxt_s = target_s;
                        state_nxt_s       = ST_REDIRECT;
                    end else begin
                        redirect_nxt_s = 1'b0;
                    end
                end
                ST_REDIRECT: begin
                    redirect_nxt_s = 1'b0;
                    state_nxt_s    = ST_SHADOW;
                end
                ST_SHADOW: begin
                    redirect_nxt_s = 1'b0;
                    state_nxt_s    = ST_IDLE;
                end
                default: begin
                    redirect_nxt_s = 1'b0;
                    state_nxt_s    = ST_IDLE;
                end
            endcase
        end
    end

    // State, flag and redirect registers; stall already folded into next values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            flag_z_r      <= 1'b0;
            flag_v_r      <= 1'b0;
            flag_n_r      <= 1'b0;
            redirect_r    <= 1'b0;
            redirect_pc_r <= {PC_W{1'b0}};
        end else begin
            state_r       <= state_nxt_s;
            flag_z_r      <= zb_s;
            flag_v_r      <= vb_s;
            flag_n_r      <= nb_s;
            redirect_r    <= redirect_nxt_s;
            redirect_pc_r <= redirect_pc_nxt_s;
        end
    end

    assign bus.flag_z      = flag_z_r;
    assign bus.flag_v      = flag_v_r;
    assign bus.flag_n      = flag_n_r;
    assign bus.addz_wr_en  = addz_wr_en_s;
    assign bus.redirect    = redirect_r;
    assign bus.redirect_pc = redirect_pc_r;
endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed self-checking bench for flag_branch_unit.
module tb_flag_branch_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    flag_branch_if #(.PC_W(16), .OFF_W(9)) bus ();

    flag_branch_unit #(.PC_W(16), .OFF_W(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.stall = 1'b0; bus.flush = 1'b0;
        bus.ex_valid = 1'b0; bus.ex_ctrl = 3'b000; bus.ex_is_addz = 1'b0;
        bus.ex_ov = 1'b0; bus.ex_zr = 1'b0; bus.ex_ne = 1'b0;
        bus.br_valid = 1'b0; bus.br_cond = 3'b000;
        bus.br_pc_inc = 16'h0000; bus.br_offset = 9'h000;
    endtask

    task automatic alu(input logic [2:0] ctrl, input logic addz, input logic zr,
                       input logic ov, input logic ne);
        bus.ex_valid = 1'b1; bus.ex_ctrl = ctrl; bus.ex_is_addz = addz;
        bus.ex_zr = zr; bus.ex_ov = ov; bus.ex_ne = ne;
    endtask

    task automatic branch(input logic [2:0] cond, input logic [15:0] pc, input logic [8:0] off);
        bus.br_valid = 1'b1; bus.br_cond = cond; bus.br_pc_inc = pc; bus.br_offset = off;
    endtask

    task automatic check_flags(input string name, input logic z, input logic v, input logic n);
        checks++;
        if ({bus.flag_z, bus.flag_v, bus.flag_n} !== {z, v, n}) begin
            $display("FAIL %s: flags zvn got %b%b%b expected %b%b%b", name,
                     bus.flag_z, bus.flag_v, bus.flag_n, z, v, n);
            errors++;
        end
    endtask

    task automatic check_redirect(input string name, input logic r, input logic [15:0] pc);
        checks++;
        if (bus.redirect !== r || (r && bus.redirect_pc !== pc)) begin
            $display("FAIL %s: redirect/pc got %b/%h expected %b/%h", name,
                     bus.redirect, bus.redirect_pc, r, pc);
            errors++;
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check_flags("reset_flags", 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.redirect !== 1'b0 || bus.redirect_pc !== 16'h0000) begin
            $display("FAIL reset_redirect: got %b/%h expected 0/0000", bus.redirect, bus.redirect_pc);
            errors++;
        end
    endtask

    task automatic test_sub_eq_bypass();
        alu(3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
        branch(3'b001, 16'h0010, 9'h1FE);
        tick();
        idle_inputs();
        check_flags("sub_flags", 1'b1, 1'b0, 1'b0);
        check_redirect("eq_bypass_redirect", 1'b1, 16'h000E);
        tick();
        check_redirect("eq_pulse_end", 1'b0, 16'h0000);
        tick();
    endtask

    task automatic test_logic_ops();
        alu(3'b010, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        check_flags("set_all_flags", 1'b1, 1'b1, 1'b1);
        alu(3'b011, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_flags("and_z_only", 1'b0, 1'b1, 1'b1);
        alu(3'b001, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check_flags("lhb_no_change", 1'b0, 1'b1, 1'b1);
        idle_inputs();
        branch(3'b010, 16'h0100, 9'h005);
        tick();
        check_redirect("gt_not_taken", 1'b0, 16'h0000);
        branch(3'b110, 16'h0100, 9'h005);
        tick();
        idle_inputs();
        check_redirect("ovfl_taken", 1'b1, 16'h0105);
        tick(); tick();
    endtask

    task automatic test_addz();
        alu(3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        alu(3'b000, 1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        checks++;
        if (bus.addz_wr_en !== 1'b0) begin
            $display("FAIL addz_en_z0: got %b expected 0", bus.addz_wr_en);
            errors++;
        end
        tick();
        check_flags("addz_blocked_flags", 1'b0, 1'b0, 1'b0);
        alu(3'b010, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        alu(3'b000, 1'b1, 1'b0, 1'b1, 1'b0);
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.addz_wr_en !== 1'b0) begin
            $display("FAIL addz_en_flush: got %b expected 0", bus.addz_wr_en);
            errors++;
        end
        bus.flush = 1'b0;
        #1;
        checks++;
        if (bus.addz_wr_en !== 1'b1) begin
            $display("FAIL addz_en_z1: got %b expected 1", bus.addz_wr_en);
            errors++;
        end
        tick();
        idle_inputs();
        check_flags("addz_updates", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        branch(3'b111, 16'h0020, 9'h010);
        tick();
        check_redirect("b2b_first", 1'b1, 16'h0030);
        branch(3'b111, 16'h0040, 9'h000);
        tick();
        check_redirect("b2b_in_redirect", 1'b0, 16'h0000);
        branch(3'b111, 16'h0050, 9'h000);
        tick();
        check_redirect("b2b_in_shadow", 1'b0, 16'h0000);
        branch(3'b111, 16'h0060, 9'h001);
        tick();
        idle_inputs();
        check_redirect("b2b_back_idle", 1'b1, 16'h0061);
        tick(); tick();
    endtask

    task automatic test_stall_flush();
        branch(3'b111, 16'h0200, 9'h1F0);
        tick();
        idle_inputs();
        check_redirect("stall_first", 1'b1, 16'h01F0);
        bus.stall = 1'b1;
        alu(3'b010, 1'b0, 1'b1, 1'b0, 1'b1);
        branch(3'b111, 16'h0300, 9'h000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_redirect($sformatf("stall_hold_%0d", i), 1'b1, 16'h01F0);
            check_flags($sformatf("stall_flags_%0d", i), 1'b0, 1'b1, 1'b0);
        end
        idle_inputs();
        tick();
        check_redirect("stall_release", 1'b0, 16'h0000);
        tick();
        bus.flush = 1'b1;
        alu(3'b010, 1'b0, 1'b1, 1'b0, 1'b1);
        branch(3'b111, 16'h0400, 9'h000);
        tick();
        idle_inputs();
        check_redirect("flush_no_redirect", 1'b0, 16'h0000);
        check_flags("flush_flags", 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid_and_wrap();
        branch(3'b111, 16'h0500, 9'h000);
        tick();
        idle_inputs();
        check_redirect("pre_reset_redirect", 1'b1, 16'h0500);
        bus.stall = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.stall = 1'b0;
        check_flags("mid_reset_flags", 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.redirect !== 1'b0 || bus.redirect_pc !== 16'h0000) begin
            $display("FAIL mid_reset_redirect: got %b/%h expected 0/0000", bus.redirect, bus.redirect_pc);
            errors++;
        end
        branch(3'b111, 16'hFFFF, 9'h001);
        tick();
        idle_inputs();
        check_redirect("wrap_target_idle", 1'b1, 16'h0000);
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_sub_eq_bypass();
        test_logic_ops();
        test_addz();
        test_back_to_back();
        test_stall_flush();
        test_reset_mid_and_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
